// File: rtl/sign_tracker_pkg.sv
// Shared types and constants for the per-channel sign tracker.
// Holds the FSM encoding and the reversal-count exponent ceiling.
package sign_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    POSITIVE = 2'b01,
    NEGATIVE = 2'b10
  } st_e;

  localparam int unsigned LOG_COUNT_MAX = 30;

  function automatic logic [4:0] sat_log(
    input logic [4:0] lc
  );
    if (lc > 5'(LOG_COUNT_MAX))
      return 5'(LOG_COUNT_MAX);
    return lc;
  endfunction

endpackage

// File: rtl/sign_tracker_channel.sv
// One channel: IDLE/NEGATIVE/POSITIVE tracker with
// hysteresis and a 2^log_count reversal threshold.
module sign_tracker_channel
  import sign_tracker_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    SYS_aclk,
  input  logic                    SYS_aresetn,
  input  logic                    beat,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [SAMPLE_WIDTH-1:0] hysteresis,
  input  logic [4:0]              log_count,
  input  logic                    mode,
  output logic                    sign,
  output logic                    sign_next,
  output logic                    flip
);

  localparam int XW = SAMPLE_WIDTH + 2;

  st_e                     state_q;
  st_e                     state_d;
  logic [SAMPLE_WIDTH-1:0] ref_q;
  logic [SAMPLE_WIDTH-1:0] ref_d;
  logic [30:0]             cnt_q;
  logic [30:0]             cnt_d;
  logic                    flip_q;
  logic                    flip_d;

  logic signed [XW-1:0]    smp_x;
  logic signed [XW-1:0]    ref_x;
  logic signed [XW-1:0]    hys_x;
  logic                    rev;
  logic [30:0]             thr;
  logic [30:0]             cnt_inc;

  // Two guard bits keep reference +/- hysteresis from wrapping.
  always_comb begin
    smp_x   = {{2{sample[SAMPLE_WIDTH-1]}}, sample};
    ref_x   = {{2{ref_q[SAMPLE_WIDTH-1]}}, ref_q};
    hys_x   = {2'b00, hysteresis};
    thr     = 31'd1 << sat_log(log_count);
    cnt_inc = cnt_q + 31'd1;
    rev     = 1'b0;
    unique case (state_q)
      NEGATIVE: rev = smp_x > (ref_x + hys_x);
      POSITIVE: rev = smp_x < (ref_x - hys_x);
      default:  rev = 1'b0;
    endcase
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state_q <= IDLE;
      ref_q   <= '0;
      cnt_q   <= '0;
      flip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      flip_q  <= flip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    flip_d  = 1'b0;
    if (beat) begin
      if (state_q == IDLE) begin
        state_d = NEGATIVE;
        ref_d   = sample;
        cnt_d   = '0;
      end else if (rev) begin
        // >= so a lowered threshold still flips on the next reversal
        if (cnt_inc >= thr) begin
          state_d = (state_q == POSITIVE) ? NEGATIVE : POSITIVE;
          ref_d   = sample;
          cnt_d   = '0;
          flip_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (mode) begin
        cnt_d = '0;
      end
    end
  end

  always_comb begin
    sign      = (state_q != NEGATIVE);
    sign_next = (state_d != NEGATIVE);
    flip      = flip_q;
  end

endmodule

// File: rtl/sign_tracker.sv
// Stream sign tracker: per-channel trackers behind a single
// output register with pass-through ready.
module sign_tracker
  import sign_tracker_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int CHANNEL_COUNT    = 2,
  parameter int AXIS_TDATA_WIDTH = SAMPLE_WIDTH * CHANNEL_COUNT
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_aresetn,
  input  logic [4:0]                  SF_log_count,
  input  logic [SAMPLE_WIDTH-1:0]     SF_hysteresis,
  input  logic                        SF_mode,
  output logic [CHANNEL_COUNT-1:0]    SF_sign,
  output logic [CHANNEL_COUNT-1:0]    SF_flip,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [CHANNEL_COUNT-1:0]    M_AXIS_tuser,
  input  logic                        M_AXIS_tready
);

  logic                     accept;
  logic [CHANNEL_COUNT-1:0] sign_nx;

  assign S_AXIS_tready = M_AXIS_tready | ~M_AXIS_tvalid;
  assign accept        = S_AXIS_tvalid & S_AXIS_tready;

  for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_ch
    sign_tracker_channel #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_ch (
      .SYS_aclk    (SYS_aclk),
      .SYS_aresetn (SYS_aresetn),
      .beat        (accept),
      .sample      (S_AXIS_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .hysteresis  (SF_hysteresis),
      .log_count   (SF_log_count),
      .mode        (SF_mode),
      .sign        (SF_sign[k]),
      .sign_next   (sign_nx[k]),
      .flip        (SF_flip[k])
    );
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tuser  <= '1;
    end else if (accept) begin
      M_AXIS_tvalid <= 1'b1;
      M_AXIS_tdata  <= S_AXIS_tdata;
      M_AXIS_tuser  <= sign_nx;
    end else if (M_AXIS_tready) begin
      M_AXIS_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_tracker.sv
// Directed and randomized checks of sign_tracker against
// an integer reference model of the reversal rules.
module tb_sign_tracker;

  logic        SYS_aclk = 1'b0;
  logic        SYS_aresetn;
  logic [4:0]  SF_log_count;
  logic [15:0] SF_hysteresis;
  logic        SF_mode;
  logic [1:0]  SF_sign;
  logic [1:0]  SF_flip;
  logic        S_AXIS_tvalid;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tready;
  logic        M_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic [1:0]  M_AXIS_tuser;
  logic        M_AXIS_tready;

  always #5 SYS_aclk = ~SYS_aclk;

  sign_tracker dut (
    .SYS_aclk      (SYS_aclk),
    .SYS_aresetn   (SYS_aresetn),
    .SF_log_count  (SF_log_count),
    .SF_hysteresis (SF_hysteresis),
    .SF_mode       (SF_mode),
    .SF_sign       (SF_sign),
    .SF_flip       (SF_flip),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tuser  (M_AXIS_tuser),
    .M_AXIS_tready (M_AXIS_tready)
  );

  int checks   = 0;
  int failures = 0;

  // reference model
  bit          m_valid;
  logic [31:0] m_data;
  logic [1:0]  m_user;
  logic [1:0]  m_sign;
  logic [1:0]  m_flip;
  bit          started [2];
  bit          pos     [2];
  int          refv    [2];
  longint      cnt     [2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_user  = 2'b11;
    m_sign  = 2'b11;
    m_flip  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      started[k] = 0;
      pos[k]     = 0;
      refv[k]    = 0;
      cnt[k]     = 0;
    end
  endtask

  task automatic model_beat(input logic [31:0] d);
    int     s;
    int     h;
    int     l;
    longint thr;
    bit     rev;
    h   = int'(SF_hysteresis);
    l   = (SF_log_count > 5'd30) ? 30 : int'(SF_log_count);
    thr = longint'(1) << l;
    for (int k = 0; k < 2; k++) begin
      s = int'($signed(d[k*16 +: 16]));
      if (!started[k]) begin
        started[k] = 1;
        pos[k]     = 0;
        refv[k]    = s;
        cnt[k]     = 0;
      end else begin
        rev = pos[k] ? (s < refv[k] - h) : (s > refv[k] + h);
        if (rev) begin
          cnt[k]++;
          if (cnt[k] >= thr) begin
            pos[k]    = !pos[k];
            refv[k]   = s;
            cnt[k]    = 0;
            m_flip[k] = 1'b1;
          end
        end else if (SF_mode) begin
          cnt[k] = 0;
        end
      end
      m_sign[k] = !started[k] || pos[k];
    end
    m_valid = 1;
    m_data  = d;
    m_user  = m_sign;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".m_tvalid"}, M_AXIS_tvalid, m_valid);
    chk({tag, ".m_tdata"},  M_AXIS_tdata,  m_data);
    chk({tag, ".m_tuser"},  M_AXIS_tuser,  m_user);
    chk({tag, ".sign"},     SF_sign,       m_sign);
    chk({tag, ".flip"},     SF_flip,       m_flip);
  endtask

  // called at posedge+1; returns at the next posedge+1
  task automatic cycle(input logic v, input logic [31:0] d,
                       input logic rdy, output bit acc);
    S_AXIS_tvalid = v;
    S_AXIS_tdata  = d;
    M_AXIS_tready = rdy;
    #1;
    chk("s_tready", S_AXIS_tready, rdy | !m_valid);
    acc = v && (rdy || !m_valid);
    @(posedge SYS_aclk);
    #1;
    m_flip = 2'b00;
    if (acc) model_beat(d);
    else if (rdy) m_valid = 0;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    SYS_aresetn   = 1'b0;
    S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b1;
    repeat (2) @(posedge SYS_aclk);
    #1;
    model_reset();
    check_outputs("reset");
    chk("reset.s_tready", S_AXIS_tready, 1'b1);
    SYS_aresetn = 1'b1;
  endtask

  function automatic logic [31:0] pk(input int c1, input int c0);
    return {16'(c1), 16'(c0)};
  endfunction

  initial begin
    bit          acc;
    bit          pend;
    logic [31:0] d;
    int          pat [8];
    logic [31:0] held;

    SF_log_count  = 5'd2;
    SF_hysteresis = 16'd0;
    SF_mode       = 1'b0;
    S_AXIS_tdata  = '0;
    do_reset();

    // ramp on ch0: capture + 4 reversals
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, pk(0, i), 1'b1, acc);
      if (i == 4) begin
        chk("ramp.flip0", SF_flip[0], 1'b1);
        chk("ramp.tuser0", M_AXIS_tuser[0], 1'b1);
      end
    end
    cycle(1'b0, '0, 1'b1, acc);
    chk("ramp.flip_one_cycle", SF_flip[0], 1'b0);

    // hysteresis: ref 100, hyst 10, threshold 1
    do_reset();
    SF_log_count  = 5'd0;
    SF_hysteresis = 16'd10;
    cycle(1'b1, pk(0, 100), 1'b1, acc);
    cycle(1'b1, pk(0, 105), 1'b1, acc);
    chk("hyst.no_flip_105", SF_flip[0], 1'b0);
    cycle(1'b1, pk(0, 111), 1'b1, acc);
    chk("hyst.flip_111", SF_flip[0], 1'b1);

    // consecutive vs cumulative counting
    pat = '{0, 1, 2, -1, 3, 4, 5, 6};
    SF_hysteresis = 16'd0;
    SF_log_count  = 5'd2;
    for (int m = 1; m >= 0; m--) begin
      do_reset();
      SF_mode = 1'(m);
      for (int i = 0; i < 8; i++) begin
        cycle(1'b1, pk(0, pat[i]), 1'b1, acc);
        if (m == 1 && i == 7) chk("mode1.flip7", SF_flip[0], 1'b1);
        if (m == 0 && i == 5) chk("mode0.flip5", SF_flip[0], 1'b1);
      end
    end

    // downstream stall for 5 cycles
    do_reset();
    SF_mode = 1'b0;
    cycle(1'b1, pk(7, 0), 1'b1, acc);
    cycle(1'b1, pk(9, 1), 1'b1, acc);
    held = M_AXIS_tdata;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, pk(50, 2), 1'b0, acc);
      chk("stall.s_tready", S_AXIS_tready, 1'b0);
      chk("stall.hold", M_AXIS_tdata, held);
    end
    cycle(1'b1, pk(50, 2), 1'b1, acc);
    chk("stall.release", M_AXIS_tdata, pk(50, 2));
    cycle(1'b1, pk(51, 3), 1'b1, acc);
    chk("stall.next", M_AXIS_tdata, pk(51, 3));

    // guard bits: 0x7FFF + 0x7FFF must not wrap negative
    do_reset();
    SF_log_count  = 5'd0;
    SF_hysteresis = 16'h7FFF;
    cycle(1'b1, 32'h0000_7FFF, 1'b1, acc);
    cycle(1'b1, 32'h0000_7FFF, 1'b1, acc);
    chk("wrap.no_flip_max", SF_flip[0], 1'b0);
    cycle(1'b1, 32'h0000_8000, 1'b1, acc);
    chk("wrap.no_flip_min", SF_flip[0], 1'b0);
    chk("wrap.sign", SF_sign[0], 1'b0);

    // asynchronous reset in the middle of a cycle
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = pk(3, 3);
    #2;
    SYS_aresetn = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge SYS_aclk);
    #1;
    SYS_aresetn = 1'b1;
    SF_hysteresis = 16'd0;
    cycle(1'b1, pk(-5, 40), 1'b1, acc);
    chk("async_rst.capture_sign", SF_sign, 2'b00);

    // randomized traffic
    pend = 0;
    d    = '0;
    for (int n = 0; n < 600; n++) begin
      if (n % 16 == 0) begin
        case ($urandom_range(0, 4))
          0: SF_log_count = 5'd0;
          1: SF_log_count = 5'd1;
          2: SF_log_count = 5'd2;
          3: SF_log_count = 5'd3;
          default: SF_log_count = 5'(31);
        endcase
        SF_hysteresis = 16'($urandom_range(0, 12));
        SF_mode       = 1'($urandom_range(0, 1));
      end
      if (!pend) begin
        if ($urandom_range(0, 9) == 0)
          d = $urandom;
        else
          d = pk($urandom_range(0, 60) - 30,
                 $urandom_range(0, 60) - 30);
        pend = 1;
      end
      cycle(1'($urandom_range(0, 3) != 0), d,
            1'($urandom_range(0, 3) != 0), acc);
      if (acc) pend = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
